// File: rtl/fp_adder_arbiter.sv
`timescale 1ns/1ps
// fp_adder_arbiter: shares one multi-cycle floating-point adder between two
// requesters. Round-robin grant, operands held for ADD_LATENCY cycles, result
// returned with the requester id over a backpressured response handshake.
module fp_adder_arbiter #(
    parameter int ADD_LATENCY = 40,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_op,
    output logic [31:0] adder_a,
    output logic [31:0] adder_b,
    output logic        adder_op,
    input  logic [31:0] adder_res,
    input  logic        adder_error,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_res,
    output logic        rsp_error,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Final counter value of the settle window: cnt runs 0..ADD_LATENCY-1.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ADD_LATENCY - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             cur_id;
    logic             gnt_vld;
    logic             gnt_id;

    // Round-robin pick: on a tie the requester that did not win last time wins.
    always_comb begin
        gnt_vld = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            gnt_id = ~last_grant;
        end else begin
            gnt_id = req1_valid;
        end
    end

    // Ready is offered only in IDLE and only to the requester being granted.
    assign req0_ready = (state == IDLE) && gnt_vld && !gnt_id;
    assign req1_ready = (state == IDLE) && gnt_vld &&  gnt_id;

    // Control FSM with registered adder operands and response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            adder_a    <= '0;
            adder_b    <= '0;
            adder_op   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_res    <= '0;
            rsp_error  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        adder_a    <= gnt_id ? req1_a  : req0_a;
                        adder_b    <= gnt_id ? req1_b  : req0_b;
                        adder_op   <= gnt_id ? req1_op : req0_op;
                        cur_id     <= gnt_id;
                        last_grant <= gnt_id;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    // Adder output is trusted only once the operands have been
                    // held for the full settle window.
                    if (cnt == LAST_CNT) begin
                        rsp_res   <= adder_res;
                        rsp_error <= adder_error;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_adder_arbiter.sv
`timescale 1ns/1ps
// Testbench for fp_adder_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level model of the arbiter and a
// behavioural floating-point adder that only gives a good answer once its
// operands have been stable long enough.
module tb_fp_adder_arbiter;

    localparam int L = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_op, req1_op;
    logic [31:0] adder_a, adder_b;
    logic        adder_op;
    logic [31:0] adder_res;
    logic        adder_error;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_error, busy;
    logic [31:0] rsp_res;

    always #5 clk = ~clk;

    fp_adder_arbiter #(.ADD_LATENCY(L), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .adder_a(adder_a), .adder_b(adder_b), .adder_op(adder_op),
        .adder_res(adder_res), .adder_error(adder_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_error(rsp_error), .busy(busy)
    );

    // ---------------- float helpers (normal numbers and zero only) ----------
    function automatic real f2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:0] == 31'd0) return 0.0;
        d = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] i2f(input int v);
        return r2f(real'(v));
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b, input logic op);
        return r2f(op ? (f2r(a) - f2r(b)) : (f2r(a) + f2r(b)));
    endfunction

    function automatic logic [31:0] rnd_f();
        return i2f(int'($urandom_range(0, 510)) - 255);
    endfunction

    // ---------------- behavioural adder ----------------
    logic [64:0] prev_opnd = '0;
    int          stab = 0;
    logic        err_inject = 1'b0;

    always @(posedge clk) begin
        prev_opnd <= {adder_a, adder_b, adder_op};
        if ({adder_a, adder_b, adder_op} === prev_opnd) stab <= stab + 1;
        else stab <= 0;
    end

    always_comb begin
        adder_res   = 32'hDEADBEEF;
        adder_error = 1'b1;
        if (stab >= L - 2) begin
            adder_res   = fp_add(adder_a, adder_b, adder_op);
            adder_error = err_inject;
        end
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- transaction model ----------------
    bit          pending = 0;
    int          age = 0;
    bit          last_g = 1;
    bit          rsp_seen = 0;
    int          n_rsp = 0;
    bit          xfer0, xfer1;
    bit          err_next = 0;
    bit          gnt_log[$];
    logic        exp_id, exp_op, exp_err;
    logic [31:0] exp_a, exp_b, exp_res;

    // One clock: observe and check at the falling edge, return just after the
    // rising edge so the caller can update stimulus.
    task automatic tick();
        bit e0, e1, ev;
        @(negedge clk);
        xfer0 = 0;
        xfer1 = 0;
        if (pending) age++;
        e0 = 0;
        e1 = 0;
        if (!pending) begin
            if (req0_valid && req1_valid) begin
                e0 = last_g;
                e1 = !last_g;
            end else begin
                e0 = req0_valid;
                e1 = req1_valid;
            end
        end
        ev = pending && (age >= L + 1);
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
        chk("busy", {31'd0, busy}, {31'd0, pending});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
        if (pending) begin
            chk("adder_a", adder_a, exp_a);
            chk("adder_b", adder_b, exp_b);
            chk("adder_op", {31'd0, adder_op}, {31'd0, exp_op});
            if (rsp_valid && !rsp_seen) begin
                rsp_seen = 1;
                chk("latency", age, L + 1);
            end
        end
        if (ev) begin
            chk("rsp_res", rsp_res, exp_res);
            chk("rsp_id", {31'd0, rsp_id}, {31'd0, exp_id});
            chk("rsp_error", {31'd0, rsp_error}, {31'd0, exp_err});
        end
        if (!rst_n) begin
            pending = 0;
            last_g  = 1;
        end else if (ev && rsp_ready) begin
            pending = 0;
            n_rsp++;
        end else if (e0 || e1) begin
            exp_id   = e1;
            exp_a    = e1 ? req1_a  : req0_a;
            exp_b    = e1 ? req1_b  : req0_b;
            exp_op   = e1 ? req1_op : req0_op;
            exp_res  = fp_add(exp_a, exp_b, exp_op);
            exp_err  = err_next;
            err_inject = err_next;
            last_g   = e1;
            gnt_log.push_back(e1);
            pending  = 1;
            age      = 0;
            rsp_seen = 0;
            xfer0    = e0;
            xfer1    = e1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic [31:0] a, input logic [31:0] b, input logic op);
        if (n == 0) begin
            req0_valid = 1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    task automatic wait_xfer(input bit drop);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!(xfer0 || xfer1) && k < 400);
        if (!(xfer0 || xfer1)) chk("xfer_timeout", 32'd0, 32'd1);
        if (drop && xfer0) req0_valid = 0;
        if (drop && xfer1) req1_valid = 0;
    endtask

    task automatic run_rsp(input int target, input bit hold);
        int k = 0;
        while (n_rsp < target && k < 400) begin
            tick();
            k++;
            if (!hold && xfer0) req0_valid = 0;
            if (!hold && xfer1) req1_valid = 0;
        end
        if (n_rsp < target) chk("rsp_timeout", n_rsp, target);
    endtask

    initial begin
        int base;
        rst_n = 0;
        req0_valid = 0; req1_valid = 0;
        req0_a = '0; req0_b = '0; req0_op = 0;
        req1_a = '0; req1_b = '0; req1_op = 0;
        rsp_ready = 1;

        // reset state
        repeat (3) tick();
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_adder_a", adder_a, 32'd0);
        chk("rst_rsp_res", rsp_res, 32'd0);
        rst_n = 1;
        tick();

        // single request from requester 0: 1.0 + 2.0
        set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
        run_rsp(n_rsp + 1, 0);
        chk("first_res_val", rsp_res, 32'h40400000);

        // requester 0 drops a queued op as requester 1 raises its own
        set_req(0, i2f(3), i2f(4), 1'b0);
        wait_xfer(0);
        set_req(0, i2f(9), i2f(2), 1'b1);
        repeat (10) tick();
        req0_valid = 0;
        set_req(1, i2f(7), i2f(3), 1'b0);
        run_rsp(n_rsp + 2, 0);
        chk("swap_gnt", {31'd0, gnt_log[gnt_log.size()-1]}, 32'd1);
        chk("swap_adder_a", adder_a, i2f(7));

        // continuous contention: grants alternate 0,1,0,1
        base = gnt_log.size();
        set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
        set_req(1, 32'h40A00000, 32'h3F800000, 1'b1);
        run_rsp(n_rsp + 4, 1);
        req0_valid = 0;
        req1_valid = 0;
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_gnt%0d", i), {31'd0, gnt_log[base+i]}, (i % 2 == 1) ? 32'd1 : 32'd0);

        // response stalled by rsp_ready low; requester 1 waits unready
        rsp_ready = 0;
        set_req(0, i2f(10), i2f(-4), 1'b0);
        wait_xfer(1);
        set_req(1, i2f(6), i2f(6), 1'b1);
        repeat (L + 11) tick();
        rsp_ready = 1;
        run_rsp(n_rsp + 2, 0);

        // adder error flag, then a clean op
        err_next = 1;
        set_req(1, i2f(20), i2f(22), 1'b0);
        run_rsp(n_rsp + 1, 0);
        err_next = 0;
        set_req(0, i2f(-8), i2f(5), 1'b1);
        run_rsp(n_rsp + 1, 0);

        // reset in the middle of the settle window
        set_req(1, i2f(11), i2f(12), 1'b0);
        wait_xfer(1);
        repeat (20) tick();
        rst_n = 0;
        repeat (2) tick();
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_rsp_res", rsp_res, 32'd0);
        chk("mid_rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("mid_rst_rsp_error", {31'd0, rsp_error}, 32'd0);
        chk("mid_rst_adder_a", adder_a, 32'd0);
        chk("mid_rst_adder_b", adder_b, 32'd0);
        chk("mid_rst_adder_op", {31'd0, adder_op}, 32'd0);
        rst_n = 1;
        set_req(0, i2f(1), i2f(1), 1'b0);
        set_req(1, i2f(2), i2f(2), 1'b0);
        wait_xfer(1);
        chk("post_rst_gnt", {31'd0, gnt_log[gnt_log.size()-1]}, 32'd0);
        run_rsp(n_rsp + 2, 0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            tick();
            rsp_ready = ($urandom_range(0, 3) != 0);
            err_next  = ($urandom_range(0, 7) == 0);
            if (xfer0 || (req0_valid && $urandom_range(0, 49) == 0)) req0_valid = 0;
            if (xfer1 || (req1_valid && $urandom_range(0, 49) == 0)) req1_valid = 0;
            if (!req0_valid && $urandom_range(0, 3) == 0) set_req(0, rnd_f(), rnd_f(), 1'($urandom_range(0, 1)));
            if (!req1_valid && $urandom_range(0, 3) == 0) set_req(1, rnd_f(), rnd_f(), 1'($urandom_range(0, 1)));
        end

        // drain
        req0_valid = 0;
        req1_valid = 0;
        rsp_ready  = 1;
        for (int k = 0; k < 300 && pending; k++) tick();
        if (pending) chk("drain_timeout", 32'd1, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
